// File: rtl/imem_load_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_load_pkg
//  Description : Shared types and constants for the instruction-memory load
//                controller: controller state encoding, core reset PC and
//                bytes-per-word used for address generation.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    // PC the core starts from once released from init mode.
    localparam logic [31:0] c_RESET_PC       = 32'h0040_0000;
    localparam int          c_BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_load_cksum.sv
`default_nettype none
// ============================================================================
//  Module      : imem_load_cksum
//  Description : Running modulo-2^32 sum of loaded program words.
//  Ports       : clk     - core clock
//                reset_n - asynchronous active-low reset
//                clear   - synchronous clear (new load accepted)
//                add_en  - add data into the sum this cycle
//                data    - word to accumulate
//                sum     - current registered sum
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_load_cksum
    import imem_load_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        add_en,
    input  logic [31:0] data,
    output logic [31:0] sum
);

    logic [31:0] r_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (clear) begin
            r_sum <= '0;
        end else if (add_en) begin
            r_sum <= r_sum + data;
        end
    end

    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_load_ctrl
//  Description : Boot-time instruction-memory loader. Accepts a program as a
//                valid/ready stream of 32-bit words, writes them to
//                consecutive word addresses from 0 and holds the fetch stage
//                in init mode until the load completes.
//  Ports       : clk, reset_n            - clock, async active-low reset
//                start, word_count       - begin a load of word_count words
//                in_valid/in_data/in_ready - loader word stream
//                init_mode, write_enable, init_address, init_instruction
//                                        - fetch-stage memory init port
//                busy, done, error       - status
//  Options     : IMEM_LOAD_CHECKSUM_EN - expect a trailing 32-bit sum word
//                and check it before releasing the core.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-2:0] word_count,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              init_mode,
    output logic              write_enable,
    output logic [ADDR_W-1:0] init_address,
    output logic [31:0]       init_instruction,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Word count needs one bit more than the word index to represent MAX_WORDS.
    localparam int                CNT_W     = ADDR_W - 1;
    localparam logic [CNT_W-1:0]  c_MAX_CNT = CNT_W'(MAX_WORDS);

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_idx;
    logic                r_init_mode;
    logic                r_write_enable;
    logic [ADDR_W-1:0]   r_init_address;
    logic [31:0]         r_init_instruction;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic                w_count_ok;
    logic                w_can_start;
    logic                w_accept_start;
    logic                w_in_ready;
    logic                w_beat;
    logic                w_last;

    assign w_count_ok     = (word_count != '0) && (word_count <= c_MAX_CNT);
    assign w_can_start    = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_accept_start = start && w_can_start && w_count_ok;
    assign w_in_ready     = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_beat         = in_valid && w_in_ready;
    assign w_last         = (r_idx == (r_count - CNT_W'(1)));

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] w_sum;

    imem_load_cksum u_cksum (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_accept_start),
        .add_en  (w_beat && (r_state == ST_LOAD)),
        .data    (in_data),
        .sum     (w_sum)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ST_IDLE;
            r_count            <= '0;
            r_idx              <= '0;
            r_init_mode        <= 1'b1;
            r_write_enable     <= 1'b0;
            r_init_address     <= '0;
            r_init_instruction <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
        end else begin
            // Strobes: a write or done lasts exactly one cycle unless re-issued.
            r_write_enable <= 1'b0;
            r_done         <= 1'b0;

            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (start) begin
                        if (w_count_ok) begin
                            r_count     <= word_count;
                            r_idx       <= '0;
                            r_error     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_init_mode <= 1'b1;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (w_beat) begin
                        r_write_enable     <= 1'b1;
                        r_init_address     <= ADDR_W'(r_idx * c_BYTES_PER_WORD);
                        r_init_instruction <= in_data;
                        r_idx              <= r_idx + CNT_W'(1);
                        if (w_last) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_RELEASE;
`endif
                        end
                    end
                end

                ST_CHECK: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    if (w_beat) begin
                        if (in_data == w_sum) begin
                            r_state <= ST_RELEASE;
                        end else begin
                            // Bad image: park in IDLE with the core still frozen.
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
`else
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`endif
                end

                ST_RELEASE: begin
                    // Final write retires this cycle while init_mode is still high.
                    r_init_mode <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= ST_RUN;
                end

                default: begin
                    r_busy      <= 1'b0;
                    r_init_mode <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready         = w_in_ready;
    assign init_mode        = r_init_mode;
    assign write_enable     = r_write_enable;
    assign init_address     = r_init_address;
    assign init_instruction = r_init_instruction;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;

endmodule
`default_nettype wire
